ascii_digit_sequencer: RTL
==========================

Name: ascii_digit_sequencer

Overview:
- Controller that sequences the combinational binary-to-ASCII digit converter.
- On `start` it latches a binary value and drives it to the converter, then steps the converter's column index from the most significant digit down to the least significant.
- Each returned ASCII code is registered, leading zeros are optionally blanked, and each character is handed to the display/character sink over a valid/ready handshake.
- It sits between the processor's result register and the display writer.

Parameters:
- size_binary, 16, width of the binary value to display.
- size_decimal, 5, number of decimal digits emitted; the column index ranges 0..size_decimal-1, with column 0 the least significant digit.
- blank_leading, 1, when 1 leading zeros are replaced by space (8'h20); when 0 every digit is emitted as is.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  size_binary  binary number to display; sampled on an accepted start.
- conv_value  output  size_binary  latched value driven to the converter `in` port.
- conv_col  output  size_decimal  column index driven to the converter `col` port.
- ascii_in  input  8  converter `out`, the ASCII code of digit conv_col.
- char_out  output  8  character presented to the sink.
- char_valid  output  1  char_out is valid.
- char_ready  input  1  sink accepts char_out this cycle.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse after the last character is accepted.
- overflow  output  1  latched value exceeds 10^size_decimal-1; only the low digits are shown.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE; conv_value=0, conv_col=0, char_out=8'h00, char_valid=0, busy=0, done=0, overflow=0, internal leading-zero flag lz=1.
- Reset asserted mid-sequence drops char_valid in the same instant; no further characters are sent, and there is no resume.
- All outputs are registered.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - busy=0.
  - On start=1: conv_value<=value; conv_col<=size_decimal-1; lz<=1; overflow<=(value > 10^size_decimal-1); goto FETCH.
- FETCH (busy=1, char_valid=0): one settle cycle for the converter.
  - If blank_leading and lz and ascii_in==8'h30 and conv_col!=0: char_out<=8'h20.
  - Otherwise: char_out<=ascii_in and lz<=0.
  - The last digit (col 0) is never blanked.
  - char_valid<=1; goto SEND.
- SEND (busy=1, char_valid=1):
  - char_out and conv_col are held stable while char_ready=0, for an unbounded number of cycles.
  - On char_ready=1: char_valid<=0. If conv_col==0, goto DONE; else conv_col<=conv_col-1 and goto FETCH.
- DONE: done=1 for exactly this cycle; busy=0; goto IDLE.
- start asserted in DONE is ignored; a new start is accepted from IDLE on the next cycle.
- start while busy is ignored; changes to value while busy have no effect (conv_value is held).
- Latency with char_ready tied high, start sampled at edge 0:
  - First char_valid at edge 2.
  - Character k (k = 0 for the first) is accepted at edge 2+2k.
  - Last handshake at edge 2*size_decimal.
  - done high in the cycle after edge 2*size_decimal+1.
- conv_col decrements by 1 only on a handshake; it never wraps below 0.
- overflow holds its value until the next accepted start or reset.

Test Plan:
- value=1234, char_ready=1 → char_out sequence 20,31,32,33,34; conv_col 4→0; done pulses once in the cycle after edge 11; busy low afterwards; overflow=0.
- value=0 → sequence 20,20,20,20,30; with blank_leading=0 → 30,30,30,30,30.
- value=65535, char_ready low for 3 cycles during the 2nd character → char_valid stays 1, char_out=35 and conv_col=3 stable throughout; the sequence resumes on ready; full output 36,35,35,33,35.
- start pulsed again at edge 4 with value=99 during the 1234 sequence → ignored; output is still 1234; a start the cycle after done is accepted.
- rst asserted while in SEND of the 3rd character → char_valid, busy and conv_col go to 0 immediately; a later start=1 with value=7 gives 20,20,20,20,37.
- size_binary=8, size_decimal=2, value=255 → overflow=1; sequence 35,35; value=99 → overflow=0; sequence 39,39.

Source files
------------

// File: rtl/ascii_digit_sequencer.sv
// -----------------------------------------------------------------------------
// ascii_digit_sequencer
//
// This block drives the external combinational binary-to-ASCII digit converter.
// It sits between the processor's result register and the display writer.
//
// When start is accepted, the block latches the binary value and drives it to
// the converter. It then steps the converter column from the most significant
// digit down to column 0. Each returned ASCII code is registered, and may be
// blanked to a space if it is a leading zero. The character is then offered to
// the character sink over a valid/ready handshake. All outputs are registered.
//
// Parameters
//   size_binary    width of the binary value to display
//   size_decimal   number of decimal digits emitted (column 0 = least significant)
//   blank_leading  1: leading zeros become spaces, 0: every digit emitted as is
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   start       in   request a conversion, sampled only while idle
//   value       in   binary number to display, sampled on an accepted start
//   conv_value  out  latched value driven to the converter input
//   conv_col    out  column index driven to the converter
//   ascii_in    in   converter output: ASCII code of digit conv_col
//   char_out    out  character presented to the sink
//   char_valid  out  char_out is valid
//   char_ready  in   sink accepts char_out this cycle
//   busy        out  a sequence is in progress
//   done        out  one-cycle pulse after the last character is accepted
//   overflow    out  latched value does not fit in size_decimal digits
// -----------------------------------------------------------------------------
module ascii_digit_sequencer #(
    parameter int size_binary   = 16,
    parameter int size_decimal  = 5,
    parameter int blank_leading = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [size_binary-1:0]  value,
    output logic [size_binary-1:0]  conv_value,
    output logic [size_decimal-1:0] conv_col,
    input  logic [7:0]              ascii_in,
    output logic [7:0]              char_out,
    output logic                    char_valid,
    input  logic                    char_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_t;

    // This function computes 10^n at elaboration time. It is used to find the
    // largest value that fits in the displayed digits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0]             MAX_VALUE   = pow10(size_decimal) - 64'd1;
    localparam int                      COL_MSD_INT = size_decimal - 1;
    localparam logic [size_decimal-1:0] COL_MSD     = COL_MSD_INT[size_decimal-1:0];
    localparam logic [size_decimal-1:0] COL_LSD     = '0;
    localparam logic [7:0]              ASCII_ZERO  = 8'h30;
    localparam logic [7:0]              ASCII_SPACE = 8'h20;

    state_t                  state_q, state_d;
    logic [size_binary-1:0]  value_q, value_d;
    logic [size_decimal-1:0] col_q,   col_d;
    logic [7:0]              char_q,  char_d;
    logic                    valid_q, valid_d;
    logic                    busy_q,  busy_d;
    logic                    done_q,  done_d;
    logic                    ovf_q,   ovf_d;
    // lz_q stays set while every digit emitted so far was a blanked zero.
    logic                    lz_q,    lz_d;

    logic [63:0]             value_ext;
    logic                    is_blankable;

    // The value is widened so the overflow compare also works when
    // size_binary is narrower than the decimal range.
    assign value_ext = 64'(value);

    // A zero is blanked only while it is still leading, and never in column 0.
    // This means the value 0 still shows as a single "0".
    assign is_blankable = (blank_leading != 0) && lz_q &&
                          (ascii_in == ASCII_ZERO) && (col_q != COL_LSD);

    // NOTE: every signal driven here gets a default first. That way no path can
    // leave a signal unassigned, and no latch is inferred.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        col_d   = col_q;
        char_d  = char_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        lz_d    = lz_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    value_d = value;
                    col_d   = COL_MSD;
                    lz_d    = 1'b1;
                    ovf_d   = (value_ext > MAX_VALUE);
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            // In this state the converter has had one cycle to settle on
            // value_q/col_q. Its result is captured here.
            ST_FETCH: begin
                if (is_blankable) begin
                    char_d = ASCII_SPACE;
                end else begin
                    char_d = ascii_in;
                    lz_d   = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_SEND;
            end

            // char_out and conv_col hold here for as long as the sink stalls.
            ST_SEND: begin
                if (char_ready) begin
                    valid_d = 1'b0;
                    if (col_q == COL_LSD) begin
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        col_d   = col_q - 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end

            // The done register rises on the edge that leaves this state. A
            // start arriving here is ignored; the next start is taken from idle.
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only. Every register
    // then samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            col_q   <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lz_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            col_q   <= col_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            lz_q    <= lz_d;
        end
    end

    assign conv_value = value_q;
    assign conv_col   = col_q;
    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule
